// File: rtl/tx_framer_if.sv
// Buffer-side handshake and serial transmit signals of the transmit framer.
// The framer side uses the master modport; the buffer/line side uses slave.
interface tx_framer_if;
    logic       input_ready;
    logic [7:0] fifo_data;
    logic       read_req;
    logic       tx_data;
    logic       tx_en;
    logic       busy;
    logic       frame_done;

    modport master (
        input  input_ready,
        input  fifo_data,
        output read_req,
        output tx_data,
        output tx_en,
        output busy,
        output frame_done
    );

    modport slave (
        output input_ready,
        output fifo_data,
        input  read_req,
        input  tx_data,
        input  tx_en,
        input  busy,
        input  frame_done
    );
endinterface

// File: rtl/tx_framer.sv
// Transmit framer: pulls PAYLOAD_BYTES bytes from the input byte buffer and
// sends them as a serial frame (preamble, payload, check byte), MSB first,
// BIT_DIV read_clk cycles per bit, followed by GAP_BITS idle bit times.
// Optional feature macro TX_FRAMER_CRC8_EN: when defined the check byte is
// CRC-8 (poly 0x07, init 0x00); otherwise it is the XOR of the payload bytes.
module tx_framer #(
    parameter int         PAYLOAD_BYTES = 10,
    parameter logic [7:0] PREAMBLE      = 8'hA5,
    parameter int         BIT_DIV       = 4,
    parameter int         GAP_BITS      = 2
) (
    input  logic         read_clk,
    input  logic         arst,
    tx_framer_if.master  bus
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PREAMBLE,
        ST_PAYLOAD,
        ST_CHECK,
        ST_GAP
    } state_t;

    localparam logic [7:0]  DIV_LAST  = 8'(BIT_DIV - 1);
    localparam logic [7:0]  BYTE_LAST = 8'(PAYLOAD_BYTES - 1);
    localparam logic [15:0] GAP_LAST  = 16'(GAP_BITS * BIT_DIV - 1);

    state_t      state_reg, state_next;
    logic [7:0]  div_cnt_reg, div_cnt_next;
    logic [2:0]  bit_cnt_reg, bit_cnt_next;
    logic [7:0]  byte_cnt_reg, byte_cnt_next;
    logic [15:0] gap_cnt_reg, gap_cnt_next;
    logic [7:0]  shift_reg, shift_next;
    logic [7:0]  check_reg, check_next;
    logic [7:0]  next_byte_reg;
    logic        rd_pending_reg;

    logic        read_req_next;
    logic        frame_done_next;
    logic        tx_active;
    logic        bit_end;
    logic        byte_end;

    // Folds one payload byte into the check accumulator.
    function automatic logic [7:0] fold(input logic [7:0] acc, input logic [7:0] data);
        logic [7:0] c;
`ifdef TX_FRAMER_CRC8_EN
        c = acc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ({c[6:0], 1'b0} ^ 8'h07) : {c[6:0], 1'b0};
        end
`else
        c = acc ^ data;
`endif
        return c;
    endfunction

    assign bit_end  = (div_cnt_reg == DIV_LAST);
    assign byte_end = bit_end && (bit_cnt_reg == 3'd7);

    // Next-state, counter and output decode for the frame sequencer.
    always_comb begin
        state_next      = state_reg;
        div_cnt_next    = div_cnt_reg;
        bit_cnt_next    = bit_cnt_reg;
        byte_cnt_next   = byte_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        shift_next      = shift_reg;
        check_next      = check_reg;
        read_req_next   = 1'b0;
        frame_done_next = 1'b0;
        tx_active       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (bus.input_ready) begin
                    state_next    = ST_PREAMBLE;
                    shift_next    = PREAMBLE;
                    check_next    = 8'h00;
                    bit_cnt_next  = 3'd0;
                    div_cnt_next  = 8'd0;
                    byte_cnt_next = 8'd0;
                end
            end

            ST_PREAMBLE, ST_PAYLOAD, ST_CHECK: begin
                tx_active = 1'b1;

                // Bit timing: hold each bit for BIT_DIV cycles, then shift.
                if (bit_end) begin
                    div_cnt_next = 8'd0;
                    bit_cnt_next = bit_cnt_reg + 3'd1;
                    shift_next   = {shift_reg[6:0], 1'b0};
                end else begin
                    div_cnt_next = div_cnt_reg + 8'd1;
                end

                // Prefetch the byte that follows the one now starting.
                if (div_cnt_reg == 8'd0 && bit_cnt_reg == 3'd0 &&
                    (state_reg == ST_PREAMBLE ||
                     (state_reg == ST_PAYLOAD && byte_cnt_reg != BYTE_LAST))) begin
                    read_req_next = 1'b1;
                end

                // Byte boundary: load the next byte on the same edge.
                if (byte_end) begin
                    case (state_reg)
                        ST_PREAMBLE: begin
                            state_next    = ST_PAYLOAD;
                            shift_next    = next_byte_reg;
                            check_next    = fold(check_reg, next_byte_reg);
                            byte_cnt_next = 8'd0;
                        end
                        ST_PAYLOAD: begin
                            if (byte_cnt_reg == BYTE_LAST) begin
                                state_next = ST_CHECK;
                                shift_next = check_reg;
                            end else begin
                                shift_next    = next_byte_reg;
                                check_next    = fold(check_reg, next_byte_reg);
                                byte_cnt_next = byte_cnt_reg + 8'd1;
                            end
                        end
                        default: begin
                            frame_done_next = 1'b1;
                            shift_next      = 8'h00;
                            gap_cnt_next    = 16'd0;
                            state_next      = (GAP_BITS == 0) ? ST_IDLE : ST_GAP;
                        end
                    endcase
                end
            end

            ST_GAP: begin
                // A waiting buffer starts the next frame right at gap end so
                // back-to-back frames keep busy high without an idle cycle.
                if (gap_cnt_reg == GAP_LAST) begin
                    if (bus.input_ready) begin
                        state_next    = ST_PREAMBLE;
                        shift_next    = PREAMBLE;
                        check_next    = 8'h00;
                        bit_cnt_next  = 3'd0;
                        div_cnt_next  = 8'd0;
                        byte_cnt_next = 8'd0;
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    gap_cnt_next = gap_cnt_reg + 16'd1;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // State and datapath registers; buffer data is captured the cycle after
    // it becomes valid (one cycle after the read strobe).
    always_ff @(posedge read_clk or negedge arst) begin
        if (!arst) begin
            state_reg      <= ST_IDLE;
            div_cnt_reg    <= 8'd0;
            bit_cnt_reg    <= 3'd0;
            byte_cnt_reg   <= 8'd0;
            gap_cnt_reg    <= 16'd0;
            shift_reg      <= 8'h00;
            check_reg      <= 8'h00;
            next_byte_reg  <= 8'h00;
            rd_pending_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_cnt_reg    <= div_cnt_next;
            bit_cnt_reg    <= bit_cnt_next;
            byte_cnt_reg   <= byte_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            shift_reg      <= shift_next;
            check_reg      <= check_next;
            rd_pending_reg <= read_req_next;
            if (rd_pending_reg) begin
                next_byte_reg <= bus.fifo_data;
            end
        end
    end

    // Outputs decode from registered state, so reset clears them at once.
    assign bus.read_req   = read_req_next;
    assign bus.frame_done = frame_done_next;
    assign bus.tx_en      = tx_active;
    assign bus.tx_data    = tx_active & shift_reg[7];
    assign bus.busy       = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_tx_framer.sv
// Randomized self-checking bench for tx_framer: two instances (default
// parameters, and a short fast configuration), each fed by a queue-based
// byte buffer; serial output is decoded and compared with frames built from
// the payload bytes that were queued.
module tb_tx_framer;
    typedef bit         bq_t[$];
    typedef logic [7:0] byte_q_t[$];

    localparam int PA = 10;
    localparam int BA = 4;
    localparam int PB = 1;
    localparam int BB = 2;

    logic clk = 1'b0;
    logic arst = 1'b0;
    always #5 clk = ~clk;

    tx_framer_if ifa ();
    tx_framer_if ifb ();

    tx_framer u_a (
        .read_clk (clk),
        .arst     (arst),
        .bus      (ifa)
    );

    tx_framer #(.PAYLOAD_BYTES(PB), .BIT_DIV(BB), .GAP_BITS(0)) u_b (
        .read_clk (clk),
        .arst     (arst),
        .bus      (ifb)
    );

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    int checks = 0;
    int errors = 0;
    bq_t en_q, dat_q, req_q, done_q, busy_q;

    // Buffer models: registered read data, ready when a full payload is held.
    always @(posedge clk) begin
        if (ifa.read_req) begin
            if (qa.size() > 0) ifa.fifo_data <= qa.pop_front();
            else               ifa.fifo_data <= 8'h00;
        end
        if (ifb.read_req) begin
            if (qb.size() > 0) ifb.fifo_data <= qb.pop_front();
            else               ifb.fifo_data <= 8'h00;
        end
    end

    always @(negedge clk) begin
        ifa.input_ready = (qa.size() >= PA);
        ifb.input_ready = (qb.size() >= PB);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] ref_check(input byte_q_t pay);
        logic [7:0] c;
        c = 8'h00;
`ifdef TX_FRAMER_CRC8_EN
        foreach (pay[k]) begin
            for (int i = 7; i >= 0; i--) begin
                logic fb;
                fb = c[7] ^ pay[k][i];
                c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
            end
        end
`else
        foreach (pay[k]) c = c ^ pay[k];
`endif
        return c;
    endfunction

    function automatic byte_q_t make_frame(input byte_q_t pay);
        byte_q_t f;
        f.push_back(8'hA5);
        foreach (pay[k]) f.push_back(pay[k]);
        f.push_back(ref_check(pay));
        return f;
    endfunction

    function automatic int ones(input bq_t q, input int from, input int to);
        int n = 0;
        for (int i = from; i < to && i < q.size(); i++) if (q[i]) n++;
        return n;
    endfunction

    function automatic int first(input bq_t q, input int from, input bit v);
        for (int i = from; i < q.size(); i++) if (q[i] == v) return i;
        return q.size();
    endfunction

    task automatic watch(input bit sel, input int n);
        en_q.delete(); dat_q.delete(); req_q.delete(); done_q.delete(); busy_q.delete();
        repeat (n) begin
            @(negedge clk);
            en_q.push_back(sel ? ifb.tx_en : ifa.tx_en);
            dat_q.push_back(sel ? ifb.tx_data : ifa.tx_data);
            req_q.push_back(sel ? ifb.read_req : ifa.read_req);
            done_q.push_back(sel ? ifb.frame_done : ifa.frame_done);
            busy_q.push_back(sel ? ifb.busy : ifa.busy);
        end
    endtask

    task automatic check_frame(input string tag, input int s, input int bd, input byte_q_t exp);
        int glitch = 0;
        for (int k = 0; k < exp.size(); k++) begin
            logic [7:0] b;
            b = 8'h00;
            for (int i = 0; i < 8; i++) begin
                int base;
                bit v;
                base = s + (k * 8 + i) * bd;
                v = (base < dat_q.size()) ? dat_q[base] : 1'b0;
                for (int j = 0; j < bd; j++) begin
                    if (base + j >= dat_q.size() || dat_q[base + j] != v) glitch++;
                end
                b = {b[6:0], v};
            end
            check($sformatf("%s_byte%0d", tag, k), b, exp[k]);
        end
        check({tag, "_bithold"}, glitch, 0);
        $display("frame %s: start %0d, %0d bytes, check byte 0x%02h", tag, s, exp.size(), exp[exp.size()-1]);
    endtask

    initial begin
        byte_q_t p1, p2;
        int s, e, s2, n;

        ifa.fifo_data = 8'h00;
        ifb.fifo_data = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_outputs_a", {ifa.tx_en, ifa.busy, ifa.read_req, ifa.frame_done, ifa.tx_data}, 0);
        check("rst_outputs_b", {ifb.tx_en, ifb.busy, ifb.read_req, ifb.frame_done, ifb.tx_data}, 0);
        arst = 1'b1;

        // Idle with nothing buffered.
        watch(0, 100);
        check("idle_req",  ones(req_q, 0, 100), 0);
        check("idle_en",   ones(en_q, 0, 100), 0);
        check("idle_busy", ones(busy_q, 0, 100), 0);
        check("idle_done", ones(done_q, 0, 100), 0);

        // Fixed payload 01..0A.
        p1.delete();
        for (int i = 1; i <= 10; i++) p1.push_back(8'(i));
        foreach (p1[k]) qa.push_back(p1[k]);
        watch(0, 420);
        s = first(en_q, 0, 1);
        check("fix_en_total", ones(en_q, 0, en_q.size()), 384);
        check("fix_en_run",   first(en_q, s, 0) - s, 384);
        check("fix_reads",    ones(req_q, 0, req_q.size()), 10);
        check("fix_done_cnt", ones(done_q, 0, done_q.size()), 1);
        check("fix_done_pos", first(done_q, 0, 1), s + 383);
        check("fix_idle_end", busy_q[busy_q.size()-1], 0);
        check_frame("fix", s, BA, make_frame(p1));

        // Two back-to-back random frames with input_ready held high.
        p1.delete(); p2.delete();
        for (int i = 0; i < 10; i++) p1.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 10; i++) p2.push_back(8'($urandom_range(0, 255)));
        foreach (p1[k]) qa.push_back(p1[k]);
        foreach (p2[k]) qa.push_back(p2[k]);
        watch(0, 820);
        s  = first(en_q, 0, 1);
        e  = first(en_q, s, 0);
        s2 = first(en_q, e, 1);
        check("b2b_len1",  e - s, 384);
        check("b2b_gap",   s2 - e, 8);
        check("b2b_len2",  first(en_q, s2, 0) - s2, 384);
        check("b2b_busy",  ones(busy_q, s, s2 + 384), s2 + 384 - s);
        check("b2b_reads", ones(req_q, 0, req_q.size()), 20);
        check("b2b_done",  ones(done_q, 0, done_q.size()), 2);
        check_frame("b2b_f1", s,  BA, make_frame(p1));
        check_frame("b2b_f2", s2, BA, make_frame(p2));

        // Reset during payload byte 5.
        for (int i = 0; i < 10; i++) qa.push_back(8'($urandom_range(0, 255)));
        n = 0;
        for (int i = 0; i < 400 && n < 197; i++) begin
            @(negedge clk);
            if (ifa.tx_en) n++;
        end
        check("arst_reached", n, 197);
        arst = 1'b0;
        #1;
        check("arst_outputs", {ifa.tx_en, ifa.busy, ifa.read_req, ifa.frame_done, ifa.tx_data}, 0);
        qa.delete();
        repeat (3) @(negedge clk);
        arst = 1'b1;
        watch(0, 50);
        check("arst_idle_req",  ones(req_q, 0, 50), 0);
        check("arst_idle_busy", ones(busy_q, 0, 50), 0);
        p1.delete();
        for (int i = 0; i < 10; i++) p1.push_back(8'($urandom_range(0, 255)));
        foreach (p1[k]) qa.push_back(p1[k]);
        watch(0, 420);
        s = first(en_q, 0, 1);
        check("rec_en_run", first(en_q, s, 0) - s, 384);
        check("rec_reads",  ones(req_q, 0, req_q.size()), 10);
        check_frame("rec", s, BA, make_frame(p1));

        // Short configuration: one 0xFF payload byte, two cycles per bit, no gap.
        p1.delete();
        p1.push_back(8'hFF);
        qb.push_back(8'hFF);
        watch(1, 70);
        s = first(en_q, 0, 1);
        check("short_en_total", ones(en_q, 0, en_q.size()), 48);
        check("short_en_run",   first(en_q, s, 0) - s, 48);
        check("short_reads",    ones(req_q, 0, req_q.size()), 1);
        check("short_done_pos", first(done_q, 0, 1), s + 47);
        check("short_idle_after", (s + 48 < busy_q.size()) ? busy_q[s + 48] : 1'b1, 0);
        check_frame("short", s, BB, make_frame(p1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
